// File: rtl/axis_pcie_tx_arb.sv
// Round-robin packet arbiter: NUM_SRC AXI-Stream PCIe TX requesters onto one
// downstream stream; ownership is held from first beat until the tlast handshake.
package axis_pcie_pkg;
    localparam int unsigned AXIS_PCIE_DW    = 64;
    localparam int unsigned AXIS_PCIE_TX_UW = 8;

    typedef struct packed {
        logic                       tvalid;
        logic [AXIS_PCIE_DW-1:0]    tdata;
        logic                       tlast;
        logic [AXIS_PCIE_TX_UW-1:0] tuser;
    } t_axis_pcie_tx;
endpackage

module axis_pcie_tx_arb
    import axis_pcie_pkg::*;
#(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned GRANT_W = $clog2(NUM_SRC)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  t_axis_pcie_tx [NUM_SRC-1:0] s_if,
    output logic [NUM_SRC-1:0]           s_if_tready,
    input  logic [NUM_SRC-1:0]           src_en,
    output t_axis_pcie_tx                m_if,
    input  logic                         m_if_tready,
    output logic [NUM_SRC-1:0]           grant,
    output logic [GRANT_W-1:0]           grant_idx,
    output logic                         busy
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state, state_nxt;
    logic [GRANT_W-1:0] idx_nxt;
    logic               armed;
    logic [NUM_SRC-1:0] req;
    t_axis_pcie_tx      own;
    logic               pkt_end;
    logic               found;
    int unsigned        cand;

    // armed holds off arbitration for the first edge after reset release,
    // so no grant can be registered before the second rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            grant_idx <= GRANT_W'(NUM_SRC - 1);
            armed     <= 1'b0;
        end else begin
            state     <= state_nxt;
            grant_idx <= idx_nxt;
            armed     <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = grant_idx;
        found     = 1'b0;
        cand      = 0;
        own       = s_if[grant_idx];
        pkt_end   = own.tvalid & m_if_tready & own.tlast;
        req       = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            req[i] = s_if[i].tvalid & src_en[i];
        end

        case (state)
            IDLE: begin
                if (armed) begin
                    // Search starts one past the previous owner and wraps.
                    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
                        cand = (32'(grant_idx) + k) % NUM_SRC;
                        if (!found && req[cand]) begin
                            found   = 1'b1;
                            idx_nxt = GRANT_W'(cand);
                        end
                    end
                end
                if (found) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (pkt_end) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state == BUSY);
        m_if        = busy ? own : '0;
        grant       = '0;
        s_if_tready = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (busy && grant_idx == GRANT_W'(i)) begin
                grant[i]       = 1'b1;
                s_if_tready[i] = m_if_tready;
            end
        end
    end

endmodule
